// File: rtl/mux4_rr_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mux4_rr_scheduler                                                          |
// | Round-robin arbiter sharing a built-in 4:1 1-bit mux; registers D[S] to Q. |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module mux4_rr_scheduler #(
  parameter int QUANTUM = 4,
  parameter int CW      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] D,
  output logic [1:0] S,
  output logic [3:0] gnt,
  output logic       Q,
  output logic       valid,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = CW'(QUANTUM - 1);

  state_t        state_q, state_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    s_q, s_d;
  logic          q_q, q_d;
  logic          valid_q, valid_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    ptr_q, ptr_d;

  logic [1:0]    arb_base;
  logic [1:0]    arb_cand;
  logic [1:0]    arb_idx;
  logic          arb_found;
  logic          release_now;

  // On release the pointer becomes S, so re-arbitration searches from S+1.
  always_comb begin
    arb_base  = (state_q == GRANT) ? s_q : ptr_q;
    arb_cand  = 2'd0;
    arb_idx   = arb_base;
    arb_found = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      arb_cand = arb_base + 2'(k);
      if (req[arb_cand]) begin
        arb_found = 1'b1;
        arb_idx   = arb_cand;
      end
    end
  end

  assign release_now = (state_q == GRANT) && (!req[s_q] || (cnt_q == CNT_MAX));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    s_d     = s_q;
    q_d     = q_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (arb_found) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << arb_idx;
          s_d     = arb_idx;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        q_d     = D[s_q];
        valid_d = 1'b1;
        cnt_d   = cnt_q + CW'(1);
        if (release_now) begin
          ptr_d = s_q;
          cnt_d = '0;
          if (arb_found) begin
            gnt_d = 4'b0001 << arb_idx;
            s_d   = arb_idx;
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        valid_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      s_q     <= 2'd0;
      q_q     <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= 2'd3;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign S     = s_q;
  assign gnt   = gnt_q;
  assign Q     = q_q;
  assign valid = valid_q;
  assign busy  = (state_q == GRANT);

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mux4_rr_scheduler                                                       |
// | Scoreboard bench: directed requests, monitor pops grant and Q expectations.|
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_mux4_rr_scheduler;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] D;
  logic [1:0] S;
  logic [3:0] gnt;
  logic       Q;
  logic       valid;
  logic       busy;

  int tests_run = 0;
  int tests_failed = 0;
  bit done = 1'b0;

  typedef struct {
    logic [3:0] g;
    logic [1:0] s;
  } gexp_t;

  gexp_t gq[$];
  logic  qq[$];

  mux4_rr_scheduler #(.QUANTUM(4), .CW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .D     (D),
    .S     (S),
    .gnt   (gnt),
    .Q     (Q),
    .valid (valid),
    .busy  (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected values for n consecutive grant cycles of one source.
  task automatic push_grants(input int src, input int n, input logic qbit);
    gexp_t e;
    for (int i = 0; i < n; i++) begin
      e.g = 4'b0001 << src;
      e.s = 2'(src);
      gq.push_back(e);
      qq.push_back(qbit);
    end
  endtask

  task automatic idle_check(input logic [1:0] exp_s, input logic exp_q);
    @(negedge clk);
    chk("idle_gnt", {4'h0, gnt}, 8'h00);
    chk("idle_busy", {7'h0, busy}, 8'h00);
    chk("idle_S_hold", {6'h0, S}, {6'h0, exp_s});
    @(negedge clk);
    chk("idle_valid", {7'h0, valid}, 8'h00);
    chk("idle_Q_hold", {7'h0, Q}, {7'h0, exp_q});
  endtask

  // Monitor: pops an expectation whenever the DUT presents a grant or valid Q.
  initial begin
    gexp_t e;
    logic  eq;
    while (!done) begin
      @(negedge clk);
      if (!done) begin
        if (gnt !== 4'b0000 || busy === 1'b1) begin
          if (gq.size() == 0) begin
            chk("unexpected_grant", {4'h0, gnt}, 8'h00);
          end else begin
            e = gq.pop_front();
            chk("grant", {1'b0, busy, S, gnt}, {1'b0, 1'b1, e.s, e.g});
          end
        end
        if (valid === 1'b1) begin
          if (qq.size() == 0) begin
            chk("unexpected_valid", {7'h0, valid}, 8'h00);
          end else begin
            eq = qq.pop_front();
            chk("Q", {7'h0, Q}, {7'h0, eq});
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    req   = 4'b1111;
    D     = 4'b0000;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_gnt", {4'h0, gnt}, 8'h00);
    chk("rst_S", {6'h0, S}, 8'h00);
    chk("rst_Q", {7'h0, Q}, 8'h00);
    chk("rst_valid", {7'h0, valid}, 8'h00);
    chk("rst_busy", {7'h0, busy}, 8'h00);
    repeat (2) @(negedge clk);
    req   = 4'b0000;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // All requesting from reset priority: 0,1,2,3,0, four cycles each.
    push_grants(0, 4, 1'b0);
    push_grants(1, 4, 1'b1);
    push_grants(2, 4, 1'b0);
    push_grants(3, 4, 1'b1);
    push_grants(0, 4, 1'b0);
    req = 4'b1111;
    D   = 4'b1010;
    repeat (20) @(negedge clk);
    req = 4'b0000;
    idle_check(2'd0, 1'b0);

    // Lone requester re-granted across quantum boundaries with no gap.
    push_grants(2, 8, 1'b1);
    req = 4'b0100;
    D   = 4'b0100;
    repeat (8) @(negedge clk);
    req = 4'b0000;
    idle_check(2'd2, 1'b1);

    // Source 1 drops early; source 3 takes over on the release edge.
    push_grants(1, 2, 1'b0);
    push_grants(3, 4, 1'b1);
    req = 4'b0010;
    D   = 4'b1000;
    repeat (2) @(negedge clk);
    req = 4'b1000;
    repeat (4) @(negedge clk);
    req = 4'b0000;
    idle_check(2'd3, 1'b1);

    // Reset in the middle of a grant to source 2.
    begin
      gexp_t e;
      e.g = 4'b0100;
      e.s = 2'd2;
      gq.push_back(e);
      gq.push_back(e);
      qq.push_back(1'b1);
    end
    req = 4'b0100;
    D   = 4'b0100;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    req = 4'b1001;
    #1;
    chk("midrst_gnt", {4'h0, gnt}, 8'h00);
    chk("midrst_S", {6'h0, S}, 8'h00);
    chk("midrst_Q", {7'h0, Q}, 8'h00);
    chk("midrst_valid", {7'h0, valid}, 8'h00);
    chk("midrst_busy", {7'h0, busy}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    D     = 4'b0001;
    push_grants(0, 4, 1'b1);
    repeat (4) @(negedge clk);
    req = 4'b0000;
    idle_check(2'd0, 1'b1);

    @(negedge clk);
    done = 1'b1;
    chk("grant_queue_drained", 8'(gq.size()), 8'h00);
    chk("q_queue_drained", 8'(qq.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
